// File: rtl/esp32_spi_btn_slave.sv
// Oversampled SPI slave for the ESP32 link: all SPI pins and buttons are synchronized
// into clk_25mhz, buttons are debounced, and a command/data pair can write the LED register.
module esp32_spi_btn_slave #(
   parameter int unsigned C_sync_stages   = 2,
   parameter int unsigned C_debounce_bits = 16,
   parameter logic [6:0]  C_btn_reset     = 7'b0000001
) (
   input  logic       clk_25mhz,
   input  logic       rst,
   input  logic       spi_csn,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic [6:0] btn,
   output logic [6:0] btn_db,
   output logic [7:0] led_reg,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_first
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;

   localparam logic [C_debounce_bits-1:0] DbLast = {{(C_debounce_bits-1){1'b1}}, 1'b0};
   localparam logic [7:0]                 CmdWriteLed = 8'h01;

   logic [C_sync_stages-1:0] csnSync_q;
   logic [C_sync_stages-1:0] sclkSync_q;
   logic [C_sync_stages-1:0] mosiSync_q;
   logic [6:0]               btnSync_q [C_sync_stages];
   logic                     sclkPrev_q;

   logic                     csnS;
   logic                     sclkS;
   logic                     mosiS;
   logic [6:0]               btnS;
   logic                     sclkRise;
   logic                     sclkFall;

   logic [C_debounce_bits-1:0] dbCnt_q [7];
   logic [C_debounce_bits-1:0] dbCnt_d [7];
   logic [6:0]                 btnDb_q, btnDb_d;

   state_t      state_q, state_d;
   logic [2:0]  bitCnt_q, bitCnt_d;
   logic [1:0]  byteCnt_q, byteCnt_d;
   logic [7:0]  shiftIn_q, shiftIn_d;
   logic [7:0]  shiftOut_q, shiftOut_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  ledReg_q, ledReg_d;
   logic        rxValid_q, rxValid_d;
   logic [7:0]  rxByte_q, rxByte_d;
   logic        rxFirst_q, rxFirst_d;
   logic [7:0]  shiftInNext;

   // Synchronizers reset to the idle levels of the lines so no phantom edge follows reset.
   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         csnSync_q  <= '1;
         sclkSync_q <= '0;
         mosiSync_q <= '0;
         sclkPrev_q <= 1'b0;
         for (int i = 0; i < int'(C_sync_stages); i++) begin
            btnSync_q[i] <= C_btn_reset;
         end
      end else begin
         csnSync_q  <= {csnSync_q[C_sync_stages-2:0], spi_csn};
         sclkSync_q <= {sclkSync_q[C_sync_stages-2:0], spi_sclk};
         mosiSync_q <= {mosiSync_q[C_sync_stages-2:0], spi_mosi};
         sclkPrev_q <= sclkSync_q[C_sync_stages-1];
         btnSync_q[0] <= btn;
         for (int i = 1; i < int'(C_sync_stages); i++) begin
            btnSync_q[i] <= btnSync_q[i-1];
         end
      end
   end

   assign csnS     = csnSync_q[C_sync_stages-1];
   assign sclkS    = sclkSync_q[C_sync_stages-1];
   assign mosiS    = mosiSync_q[C_sync_stages-1];
   assign btnS     = btnSync_q[C_sync_stages-1];
   assign sclkRise = sclkS & ~sclkPrev_q;
   assign sclkFall = ~sclkS & sclkPrev_q;

   // Acceptance fires on the cycle the counter would reach all-ones, so the
   // input must differ for 2^C_debounce_bits - 1 consecutive cycles.
   always_comb begin
      btnDb_d = btnDb_q;
      for (int i = 0; i < 7; i++) begin
         dbCnt_d[i] = dbCnt_q[i];
         if (btnS[i] == btnDb_q[i]) begin
            dbCnt_d[i] = '0;
         end else if (dbCnt_q[i] == DbLast) begin
            btnDb_d[i] = btnS[i];
            dbCnt_d[i] = '0;
         end else begin
            dbCnt_d[i] = dbCnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         btnDb_q <= C_btn_reset;
         for (int i = 0; i < 7; i++) begin
            dbCnt_q[i] <= '0;
         end
      end else begin
         btnDb_q <= btnDb_d;
         for (int i = 0; i < 7; i++) begin
            dbCnt_q[i] <= dbCnt_d[i];
         end
      end
   end

   assign shiftInNext = {shiftIn_q[6:0], mosiS};

   // The falling edge right after a byte completes is skipped (bit counter back at 0)
   // so bit 7 of the freshly reloaded byte stays on MISO for the next rising edge.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      byteCnt_d  = byteCnt_q;
      shiftIn_d  = shiftIn_q;
      shiftOut_d = shiftOut_q;
      cmd_d      = cmd_q;
      ledReg_d   = ledReg_q;
      rxValid_d  = 1'b0;
      rxByte_d   = rxByte_q;
      rxFirst_d  = 1'b0;

      case (state_q)
         IDLE: begin
            bitCnt_d   = '0;
            byteCnt_d  = '0;
            shiftOut_d = {1'b0, btnDb_q};
            if (!csnS) begin
               state_d = CMD;
            end
         end
         default: begin
            if (csnS) begin
               state_d = IDLE;
            end else if (sclkRise) begin
               shiftIn_d = shiftInNext;
               bitCnt_d  = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  rxValid_d  = 1'b1;
                  rxByte_d   = shiftInNext;
                  rxFirst_d  = (byteCnt_q == 2'd0);
                  shiftOut_d = ledReg_q;
                  if (byteCnt_q != 2'd2) begin
                     byteCnt_d = byteCnt_q + 2'd1;
                  end
                  case (state_q)
                     CMD: begin
                        cmd_d   = shiftInNext;
                        state_d = DATA;
                     end
                     DATA: begin
                        if (cmd_q == CmdWriteLed) begin
                           ledReg_d = shiftInNext;
                        end
                        state_d = DRAIN;
                     end
                     default: begin
                     end
                  endcase
               end
            end else if (sclkFall && (bitCnt_q != 3'd0)) begin
               shiftOut_d = {shiftOut_q[6:0], 1'b0};
            end
         end
      endcase
   end

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         byteCnt_q  <= '0;
         shiftIn_q  <= '0;
         shiftOut_q <= '0;
         cmd_q      <= '0;
         ledReg_q   <= '0;
         rxValid_q  <= 1'b0;
         rxByte_q   <= '0;
         rxFirst_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         byteCnt_q  <= byteCnt_d;
         shiftIn_q  <= shiftIn_d;
         shiftOut_q <= shiftOut_d;
         cmd_q      <= cmd_d;
         ledReg_q   <= ledReg_d;
         rxValid_q  <= rxValid_d;
         rxByte_q   <= rxByte_d;
         rxFirst_q  <= rxFirst_d;
      end
   end

   assign spi_miso    = shiftOut_q[7];
   assign spi_miso_oe = (state_q != IDLE);
   assign btn_db      = btnDb_q;
   assign led_reg     = ledReg_q;
   assign rx_valid    = rxValid_q;
   assign rx_byte     = rxByte_q;
   assign rx_first    = rxFirst_q;

endmodule
